osd_dem_uart_arb: RTL and testbench
===================================

// Module: osd_dem_uart_arb
// PURPOSE
//  Shares one DEM-UART character port among N_SRC producers, e.g. per-core stdout.
//  TX: round-robin arbiter with line locking, so characters from different sources do not interleave mid-line.
//  RX: steers host-to-target characters from the DEM-UART to one selectable consumer.
//  Sits between the per-core char streams and the out_*/in_* ports of the debug UART module.
// PARAMETERS
//  N_SRC      4      number of producer/consumer channels (>=2)
//  MAX_BURST  64     max chars per grant before forced release (>=1)
//  TIMEOUT    256    idle cycles of granted source before release (>=1)
//  LOCK_CHAR  8'h0A  char that ends a grant (newline)
// PORTS
//  clk        in   1        clock
//  rst        in   1        synchronous, active-high reset
//  src_char   in   8*N_SRC  producer chars, channel i at [8i+7:8i]
//  src_valid  in   N_SRC    producer valid
//  src_ready  out  N_SRC    producer ready
//  out_char   out  8        char to DEM-UART
//  out_valid  out  1        char valid to DEM-UART
//  out_ready  in   1        DEM-UART accepts (low while stalled)
//  in_char    in   8        char from DEM-UART
//  in_valid   in   1        char valid from DEM-UART
//  in_ready   out  1        ready to DEM-UART
//  rx_sel     in   $clog2(N_SRC)  requested RX destination channel
//  dst_char   out  8        RX char, broadcast to all consumers
//  dst_valid  out  N_SRC    one-hot RX valid
//  dst_ready  in   N_SRC    consumer ready
//  grant      out  N_SRC    one-hot current TX owner, 0 when idle
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, last=N_SRC-1, burst_cnt=0, idle_cnt=0, rx_sel_q=0.
//  Reset outputs: out_valid=0, src_ready=0, dst_valid=0, in_ready=dst_ready[0].
//  Reset mid-burst discards the lock; no char is duplicated or emitted.
//  TX FSM, IDLE:
//   - out_valid=0, src_ready=0.
//   - If any src_valid: grant <= first valid index after last, wrapping modulo N_SRC.
//   - Counters clear; state <= LOCKED. Grant latency is 1 cycle.
//  TX FSM, LOCKED (g = granted index):
//   - out_char=src_char[g], out_valid=src_valid[g], src_ready[g]=out_ready.
//   - All other src_ready=0. Path is combinational, zero latency.
//   - Xfer = out_valid & out_ready: burst_cnt++, idle_cnt <= 0.
//   - Cycle with src_valid[g]=0: idle_cnt++.
//   - out_ready=0 with src_valid[g]=1 (DEM stall) does not count as idle.
//   - Release (state <= IDLE, last <= g, grant <= 0) when any of:
//     (a) xfer with char == LOCK_CHAR;
//     (b) xfer making burst_cnt == MAX_BURST;
//     (c) idle_cnt reaches TIMEOUT-1 while src_valid[g]=0.
//   - Simultaneous (a) and (b): a single release.
//   - After release, IDLE lasts >=1 cycle; next grant goes to the next requester after g.
//  Counters are $clog2(MAX_BURST+1) and $clog2(TIMEOUT+1) bits; they never wrap.
//  RX path:
//   - dst_char=in_char; dst_valid[rx_sel_q]=in_valid, others 0; in_ready=dst_ready[rx_sel_q].
//   - rx_sel_q <= rx_sel only when !in_valid or on RX xfer, so a pending char is never re-steered.
//   - rx_sel >= N_SRC is ignored (rx_sel_q holds).
// TESTING
//  T1 reset: src_valid=4'b1111 during rst -> grant=0, out_valid=0; grant=4'b0001 one cycle after rst drops.
//  T2 line lock: src0 sends "ab\n" while src1 valid -> out sequence a,b,0x0A from src0,
//     one IDLE cycle, then grant=4'b0010.
//  T3 burst cap: MAX_BURST=4, src2 streams 6 chars without 0x0A -> 4 chars, release,
//     other requesters served, then the remaining 2.
//  T4 stall vs timeout: TIMEOUT=8, out_ready=0 for 20 cycles with src_valid held -> no release.
//     src_valid=0 for 8 cycles -> release.
//  T5 RX steer: rx_sel=2, in_char=0x41, dst_ready[2]=0 for 3 cycles while rx_sel changes to 1 ->
//     dst_valid=4'b0100 held; char delivered to ch2; next char goes to ch1.
//  T6 reset mid-burst: rst asserted after 2 of 5 chars -> outputs idle next cycle, no extra xfer.

Source files
------------

// File: rtl/osd_dem_uart_arb.sv
// rtl/osd_dem_uart_arb.sv - line-locking round-robin TX arbiter and steered RX path for one DEM-UART port
module osd_dem_uart_arb #(
  parameter int         N_SRC     = 4,
  parameter int         MAX_BURST = 64,
  parameter int         TIMEOUT   = 256,
  parameter logic [7:0] LOCK_CHAR = 8'h0A
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [8*N_SRC-1:0]       src_char,
  input  logic [N_SRC-1:0]         src_valid,
  output logic [N_SRC-1:0]         src_ready,
  output logic [7:0]               out_char,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic [7:0]               in_char,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(N_SRC)-1:0] rx_sel,
  output logic [7:0]               dst_char,
  output logic [N_SRC-1:0]         dst_valid,
  input  logic [N_SRC-1:0]         dst_ready,
  output logic [N_SRC-1:0]         grant
);

  localparam int SW = $clog2(N_SRC);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [SW:0]   N_LIM     = (SW + 1)'(N_SRC);
  localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] IDLE_END  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] IDLE_SAT  = TW'(TIMEOUT);

  logic [0:0]    state;
  logic [SW-1:0] gidx;
  logic [SW-1:0] last;
  logic [SW-1:0] nxt_idx;
  logic [SW-1:0] cand;
  logic [SW-1:0] rx_sel_q;
  logic [BW-1:0] burst_cnt;
  logic [TW-1:0] idle_cnt;
  logic          locked;
  logic          g_valid;
  logic          xfer;
  logic          release_now;
  logic          rx_xfer;

  // Outputs are gated by rst so a character presented in the reset cycle is never handshaken.
  assign locked   = (state == LOCKED) && !rst;
  assign g_valid  = src_valid[gidx];
  assign out_char = src_char[{gidx, 3'b000} +: 8];
  assign out_valid = locked & g_valid;
  assign xfer      = out_valid & out_ready;

  assign release_now = locked &&
                       ((xfer && ((out_char == LOCK_CHAR) || (burst_cnt == BURST_END))) ||
                        (!g_valid && (idle_cnt == IDLE_END)));

  always_comb begin
    src_ready = '0;
    grant     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (locked && (gidx == SW'(i))) begin
        grant[i]     = 1'b1;
        src_ready[i] = out_ready;
      end
    end
  end

  // Scan from farthest to nearest so the first requester after last wins.
  always_comb begin
    nxt_idx = last;
    cand    = last;
    for (int k = N_SRC; k >= 1; k--) begin
      cand = SW'((int'(last) + k) % N_SRC);
      if (src_valid[cand]) nxt_idx = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gidx      <= '0;
      last      <= SW'(N_SRC - 1);
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else if (state == IDLE) begin
      burst_cnt <= '0;
      idle_cnt  <= '0;
      if (|src_valid) begin
        gidx  <= nxt_idx;
        state <= LOCKED;
      end
    end else if (release_now) begin
      state     <= IDLE;
      last      <= gidx;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else if (xfer) begin
      burst_cnt <= burst_cnt + 1'b1;
      idle_cnt  <= '0;
    end else if (!g_valid && (idle_cnt != IDLE_SAT)) begin
      // A stalled sink with data pending is not idleness; only an empty source counts.
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign dst_char = in_char;
  assign in_ready = dst_ready[rx_sel_q];
  assign rx_xfer  = in_valid & dst_ready[rx_sel_q];

  always_comb begin
    dst_valid           = '0;
    dst_valid[rx_sel_q] = in_valid;
  end

  // Re-steer only between characters so a pending one never changes destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sel_q <= '0;
    end else if ((!in_valid || rx_xfer) && ({1'b0, rx_sel} < N_LIM)) begin
      rx_sel_q <= rx_sel;
    end
  end

endmodule

// File: tb/tb_osd_dem_uart_arb.sv
// tb/tb_osd_dem_uart_arb.sv - scoreboard bench for osd_dem_uart_arb
module tb_osd_dem_uart_arb;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [8*N-1:0] src_char = '0;
  logic [N-1:0]   src_valid = '0;
  logic [N-1:0]   src_ready;
  logic [7:0]     out_char;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [7:0]     in_char = 8'h00;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [1:0]     rx_sel = 2'd0;
  logic [7:0]     dst_char;
  logic [N-1:0]   dst_valid;
  logic [N-1:0]   dst_ready = 4'b1110;
  logic [N-1:0]   grant;

  osd_dem_uart_arb #(
    .N_SRC(4), .MAX_BURST(4), .TIMEOUT(8), .LOCK_CHAR(8'h0A)
  ) dut (
    .clk(clk), .rst(rst),
    .src_char(src_char), .src_valid(src_valid), .src_ready(src_ready),
    .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
    .in_char(in_char), .in_valid(in_valid), .in_ready(in_ready),
    .rx_sel(rx_sel), .dst_char(dst_char), .dst_valid(dst_valid), .dst_ready(dst_ready),
    .grant(grant)
  );

  always #5 clk = ~clk;

  logic [7:0]  srcq [N][$];
  logic [15:0] exp_tx [$];
  logic [15:0] exp_rx [$];
  int          pops [N];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic feed(input int s, input string str);
    for (int i = 0; i < str.len(); i++) srcq[s].push_back(str[i]);
  endtask

  task automatic expect_tx(input int s, input string str);
    for (int i = 0; i < str.len(); i++) exp_tx.push_back({8'(s), str[i]});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_tx_empty(input int limit, input string name);
    for (int c = 0; c < limit && exp_tx.size() > 0; c++) @(negedge clk);
    check(name, exp_tx.size(), 0);
  endtask

  task automatic wait_grant(input logic [N-1:0] g, input int limit, input string name);
    for (int c = 0; c < limit && grant !== g; c++) @(negedge clk);
    check(name, grant, g);
  endtask

  // Producers: hold the head char valid until the DUT accepts it.
  initial begin : feeder
    logic [N-1:0] acc;
    for (int i = 0; i < N; i++) pops[i] = 0;
    forever begin
      @(negedge clk);
      acc = src_valid & src_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && srcq[i].size() > 0) begin
          void'(srcq[i].pop_front());
          pops[i]++;
        end
        src_valid[i]         = (srcq[i].size() > 0);
        src_char[8*i +: 8]   = (srcq[i].size() > 0) ? srcq[i][0] : 8'h00;
      end
    end
  end

  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_tx.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL tx_unexpected: got char %0h grant %b, want no transfer", out_char, grant);
        end else begin
          e = exp_tx.pop_front();
          check("tx_char", out_char, e[7:0]);
          check("tx_grant", grant, 32'(1) << e[15:8]);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (dst_valid[i] && dst_ready[i]) begin
          if (exp_rx.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx_unexpected: got char %0h on ch %0d, want no transfer", dst_char, i);
          end else begin
            e = exp_rx.pop_front();
            check("rx_char", dst_char, e[7:0]);
            check("rx_channel", i, e[15:8]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic found;
    int   base;

    // T1: reset with all producers requesting
    rx_sel = 2'd2;
    feed(0, "0\n"); feed(1, "1\n"); feed(2, "2\n"); feed(3, "3\n");
    expect_tx(0, "0\n"); expect_tx(1, "1\n"); expect_tx(2, "2\n"); expect_tx(3, "3\n");
    repeat (3) step();
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_in_ready", in_ready, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t1_idle_after_rst", grant, 0);
    @(negedge clk);
    check("t1_first_grant", grant, 4'b0001);
    wait_tx_empty(100, "t1_drain");

    // T2: line lock keeps src1 waiting until src0's newline
    step();
    feed(0, "ab\n"); feed(1, "x\n");
    expect_tx(0, "ab\n"); expect_tx(1, "x\n");
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_char == 8'h0A && grant == 4'b0001) found = 1'b1;
    end
    check("t2_lf_seen", found, 1);
    @(negedge clk);
    check("t2_idle_gap", grant, 0);
    @(negedge clk);
    check("t2_next_grant", grant, 4'b0010);
    wait_tx_empty(100, "t2_drain");

    // T3: burst cap of 4, others served before the remainder
    step();
    feed(2, "ABCDEF"); feed(3, "p\n"); feed(0, "q\n");
    expect_tx(2, "ABCD"); expect_tx(3, "p\n"); expect_tx(0, "q\n"); expect_tx(2, "EF");
    wait_tx_empty(200, "t3_drain");
    wait_grant(4'b0000, 40, "t3_timeout_release");

    // T4: sink stall is not idle; an empty source times out after 8 cycles
    step();
    out_ready = 1'b0;
    feed(3, "s");
    expect_tx(3, "s");
    wait_grant(4'b1000, 20, "t4_grant");
    repeat (20) @(negedge clk);
    check("t4_stall_grant", grant, 4'b1000);
    check("t4_stall_valid", out_valid, 1);
    step();
    out_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) found = 1'b1;
    end
    check("t4_xfer_seen", found, 1);
    repeat (8) @(negedge clk);
    check("t4_before_timeout", grant, 4'b1000);
    @(negedge clk);
    check("t4_timeout", grant, 4'b0000);

    // T5: RX pending char stays on ch2 while rx_sel moves to 1
    step();
    rx_sel = 2'd2;
    step();
    in_valid  = 1'b1;
    in_char   = 8'h41;
    dst_ready = 4'b1011;
    exp_rx.push_back({8'd2, 8'h41});
    step();
    rx_sel = 2'd1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t5_hold", dst_valid, 4'b0100);
    end
    check("t5_in_ready_low", in_ready, 0);
    step();
    dst_ready = 4'b1111;
    step();
    in_char = 8'h42;
    exp_rx.push_back({8'd1, 8'h42});
    @(negedge clk);
    check("t5_next_ch", dst_valid, 4'b0010);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_rx_drain", exp_rx.size(), 0);

    // T6: reset after 2 of 5 chars drops the rest
    step();
    base = pops[3];
    feed(3, "12345");
    expect_tx(3, "12");
    for (int c = 0; c < 50 && (pops[3] - base) < 2; c++) step();
    check("t6_two_sent", pops[3] - base, 2);
    rst = 1'b1;
    srcq[3].delete();
    @(negedge clk);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_src_ready", src_ready, 0);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_grant_after_rst", grant, 0);
    repeat (5) @(negedge clk);
    check("t6_quiet", out_valid, 0);
    wait_tx_empty(5, "t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
